// File: rtl/score_bcd_scheduler_pkg.sv
// rtl/score_bcd_scheduler_pkg.sv - shared types, defaults and helpers for the score BCD scheduler
package score_bcd_scheduler_pkg;

    localparam int SCORE_W_DEF   = 8;
    localparam int MAX_SCORE_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [1:0] ndig_t;

    localparam ndig_t NDIG_ONE   = 2'd1;
    localparam ndig_t NDIG_TWO   = 2'd2;
    localparam ndig_t NDIG_THREE = 2'd3;

    // One player's three decimal digits plus how many of them are significant
    typedef struct packed {
        bcd_digit_t hun;
        bcd_digit_t ten;
        bcd_digit_t one;
        ndig_t      ndig;
    } disp_t;

    localparam disp_t DISP_ZERO = {4'd0, 4'd0, 4'd0, NDIG_ONE};

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled
    function automatic bcd_digit_t dd_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Leading zeros are suppressed, but a value of zero still shows one digit
    function automatic ndig_t ndig_of(input bcd_digit_t hun, input bcd_digit_t ten);
        if (hun != 4'd0) begin
            return NDIG_THREE;
        end
        if (ten != 4'd0) begin
            return NDIG_TWO;
        end
        return NDIG_ONE;
    endfunction

endpackage

// File: rtl/score_bcd_scheduler_bcd_dd_engine.sv
// rtl/score_bcd_scheduler_bcd_dd_engine.sv - iterative double-dabble binary to 3-digit BCD converter
module bcd_dd_engine
    import score_bcd_scheduler_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SCORE_W-1:0] bin_in,
    output logic               done,
    output bcd_digit_t         hun,
    output bcd_digit_t         ten,
    output bcd_digit_t         one
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        bcd_adj;

    // Load on start, then one adjust-and-shift per cycle until the counter drains
    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        bcd_adj = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
        if (abort) begin
            cnt_d = '0;
        end else if (start) begin
            bin_d = bin_in;
            bcd_d = '0;
            cnt_d = CNT_W'(SCORE_W);
        end else if (cnt_q != '0) begin
            bcd_d = {bcd_adj[10:0], bin_q[SCORE_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    // Flags the cycle that performs the final iteration, so the digits are settled one cycle later
    assign done = (cnt_q == CNT_W'(1));
    assign hun  = bcd_q[11:8];
    assign ten  = bcd_q[7:4];
    assign one  = bcd_q[3:0];

endmodule

// File: rtl/score_bcd_scheduler.sv
// rtl/score_bcd_scheduler.sv - two score counters sharing one BCD converter with frame-synchronous display
module score_bcd_scheduler
    import score_bcd_scheduler_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int MAX_SCORE = MAX_SCORE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               frame_start,
    input  logic               score_clr,
    input  logic               score_inc_0,
    input  logic               score_inc_1,
    output logic [SCORE_W-1:0] score_0,
    output logic [SCORE_W-1:0] score_1,
    output logic [3:0]         hun_0,
    output logic [3:0]         ten_0,
    output logic [3:0]         one_0,
    output logic [1:0]         ndig_0,
    output logic [3:0]         hun_1,
    output logic [3:0]         ten_1,
    output logic [3:0]         one_1,
    output logic [1:0]         ndig_1,
    output logic               busy
);

    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [1:0]         dirty_q, dirty_d;
    logic [SCORE_W-1:0] score_0_q, score_0_d;
    logic [SCORE_W-1:0] score_1_q, score_1_d;
    disp_t              shadow_0_q, shadow_0_d;
    disp_t              shadow_1_q, shadow_1_d;
    disp_t              disp_0_q, disp_0_d;
    disp_t              disp_1_q, disp_1_d;

    logic               gnt;
    logic [1:0]         grant_clr;
    logic [1:0]         inc_acc;
    logic               eng_start;
    logic [SCORE_W-1:0] eng_bin;
    logic               eng_done;
    bcd_digit_t         eng_hun, eng_ten, eng_one;
    logic               shadow_wr;
    disp_t              conv_result;

    bcd_dd_engine #(
        .SCORE_W (SCORE_W)
    ) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (eng_start),
        .abort  (score_clr),
        .bin_in (eng_bin),
        .done   (eng_done),
        .hun    (eng_hun),
        .ten    (eng_ten),
        .one    (eng_one)
    );

    // Saturating score counters; player 1 only counts in two-player mode
    always_comb begin
        inc_acc   = {score_inc_1 & mode, score_inc_0};
        score_0_d = score_0_q;
        score_1_d = score_1_q;
        if (score_clr) begin
            score_0_d = '0;
            score_1_d = '0;
        end else begin
            if (inc_acc[0] && (score_0_q < MAX_VAL)) begin
                score_0_d = score_0_q + SCORE_W'(1);
            end
            if (inc_acc[1] && (score_1_q < MAX_VAL)) begin
                score_1_d = score_1_q + SCORE_W'(1);
            end
        end
    end

    // Round-robin arbiter and conversion sequencing; a restart aborts whatever is in flight
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt          = 1'b0;
        grant_clr    = 2'b00;
        eng_start    = 1'b0;
        eng_bin      = score_0_q;
        shadow_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dirty_q != 2'b00) begin
                    gnt            = (dirty_q == 2'b11) ? ~last_grant_q : dirty_q[1];
                    last_grant_d   = gnt;
                    grant_clr[gnt] = 1'b1;
                    eng_start      = 1'b1;
                    eng_bin        = gnt ? score_1_q : score_0_q;
                    state_d        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                shadow_wr = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (score_clr) begin
            state_d      = ST_IDLE;
            last_grant_d = last_grant_q;
            grant_clr    = 2'b00;
            eng_start    = 1'b0;
            shadow_wr    = 1'b0;
        end
    end

    // A new increment wins over the grant clearing its flag, so a snapshot never hides a later point
    always_comb begin
        if (score_clr) begin
            dirty_d = 2'b00;
        end else begin
            dirty_d = (dirty_q & ~grant_clr) | inc_acc;
        end
    end

    // Shadow capture from the engine and frame-synchronous copy to the display with write-through
    always_comb begin
        conv_result = {eng_hun, eng_ten, eng_one, ndig_of(eng_hun, eng_ten)};
        shadow_0_d  = shadow_0_q;
        shadow_1_d  = shadow_1_q;
        disp_0_d    = disp_0_q;
        disp_1_d    = disp_1_q;
        if (score_clr) begin
            shadow_0_d = DISP_ZERO;
            shadow_1_d = DISP_ZERO;
        end else begin
            if (shadow_wr) begin
                if (last_grant_q) begin
                    shadow_1_d = conv_result;
                end else begin
                    shadow_0_d = conv_result;
                end
            end
            if (frame_start) begin
                disp_0_d = shadow_0_d;
                disp_1_d = shadow_1_d;
            end
        end
    end

    // State, counters, flags and digit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            dirty_q      <= 2'b00;
            score_0_q    <= '0;
            score_1_q    <= '0;
            shadow_0_q   <= DISP_ZERO;
            shadow_1_q   <= DISP_ZERO;
            disp_0_q     <= DISP_ZERO;
            disp_1_q     <= DISP_ZERO;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dirty_q      <= dirty_d;
            score_0_q    <= score_0_d;
            score_1_q    <= score_1_d;
            shadow_0_q   <= shadow_0_d;
            shadow_1_q   <= shadow_1_d;
            disp_0_q     <= disp_0_d;
            disp_1_q     <= disp_1_d;
        end
    end

    assign score_0 = score_0_q;
    assign score_1 = score_1_q;
    assign hun_0   = disp_0_q.hun;
    assign ten_0   = disp_0_q.ten;
    assign one_0   = disp_0_q.one;
    assign ndig_0  = disp_0_q.ndig;
    assign hun_1   = disp_1_q.hun;
    assign ten_1   = disp_1_q.ten;
    assign one_1   = disp_1_q.one;
    assign ndig_1  = disp_1_q.ndig;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/score_bcd_scheduler.md
Name: score_bcd_scheduler

Overview:
Owns both players' score counters and shares one iterative double-dabble binary-to-BCD engine between them. Round-robin arbitration decides which player's score is converted next. Each result is latched into a per-player shadow register, and the display-facing digit registers copy from the shadow only on the frame_start pulse, so digits never change mid-frame. Sits between the game-logic scoring events and the number-glyph pixel/ROM addressing path.

Parameters:
SCORE_W, 8, score counter width; also the number of shift iterations per conversion
MAX_SCORE, 255, saturation value of each score counter (must be <= 2**SCORE_W-1 and <= 999)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = single player (player 1 is inert), 1 = two player
frame_start  in  1  one-cycle pulse at start of vertical blank
score_clr  in  1  one-cycle pulse: restart game
score_inc_0  in  1  one-cycle pulse: player 0 scores
score_inc_1  in  1  one-cycle pulse: player 1 scores
score_0  out  SCORE_W  player 0 binary score
score_1  out  SCORE_W  player 1 binary score
hun_0, ten_0, one_0  out  4 each  player 0 displayed BCD digits
ndig_0  out  2  player 0 significant digit count (1..3)
hun_1, ten_1, one_1  out  4 each  player 1 displayed BCD digits
ndig_1  out  2  player 1 significant digit count
busy  out  1  conversion engine active

Behaviour:
- Reset, asynchronous and active-low: scores = 0, all digits = 0, ndig = 1, busy = 0, both dirty flags = 0, last_grant = 1 (so player 0 wins the first tie), FSM = IDLE.
- Counters: score_inc_x increments score_x at the next edge and saturates at MAX_SCORE.
  - Every accepted increment sets dirty_x, even when the count is already saturated.
  - When mode = 0, score_inc_1 is ignored and dirty_1 is never set by an increment.
- score_clr has priority over any same-cycle increment or frame_start.
  - Effects: both scores = 0, shadow digits = 0 with ndig = 1, FSM forced to IDLE (any in-flight conversion is aborted), busy = 0, both dirty flags = 0.
  - Display registers take the zeroed shadow at the next frame_start.
- FSM states:
  - IDLE: if any dirty flag is set, grant. With both set, grant the player that is not last_grant. Snapshot that score into the shift register, clear BCD accumulators, clear the granted dirty flag, set last_grant, go to SHIFT. busy goes high at the same edge.
  - SHIFT: exactly SCORE_W cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After the last iteration go to DONE.
  - DONE: write {hun, ten, one} into the granted player's shadow. ndig = 3 if hun != 0, 2 if ten != 0, else 1. Then go to IDLE; busy drops at this edge.
- Latency: dirty visible in IDLE at cycle N -> shadow valid at edge N+SCORE_W+2 (10 cycles at default). A back-to-back grant follows from IDLE one cycle later.
- An increment to the granted player during SHIFT/DONE re-sets its dirty flag; the converted value stays the snapshot.
- frame_start copies both shadows to the display registers.
  - If DONE writes a shadow in the same cycle, the display takes the newly written value (write-through).
  - With no frame_start, display registers hold indefinitely.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package: SCORE_W, MAX_SCORE default, FSM state encoding (IDLE/SHIFT/DONE), BCD digit type (4-bit), ndig encoding.
- One sub-module is natural: bcd_dd_engine, the iterative double-dabble datapath (start, bin_in, done, hun/ten/one), instanced once.
- Counters, arbiter, FSM and shadow/display registers stay in the top.

Test Plan:
- Reset, then 7 pulses on score_inc_0, then frame_start -> score_0 = 7, one_0 = 7, ten_0 = 0, hun_0 = 0, ndig_0 = 1, busy pulses; display is unchanged before frame_start.
- mode = 1, score_inc_0 and score_inc_1 in the same cycle with both scores at 9 -> player 0 converted first, player 1 starts 1 cycle after player 0's DONE; after frame_start both show ten = 1, one = 0, ndig = 2.
- 300 pulses on score_inc_0 -> score_0 saturates at 255; display hun/ten/one = 2/5/5, ndig_0 = 3.
- score_clr asserted mid-SHIFT with a score_inc_0 in the same cycle -> score_0 = 0, busy = 0 next cycle, no shadow write; after frame_start all digits = 0, ndig = 1.
- mode = 0, pulses on score_inc_1 -> score_1 stays 0, no conversion is granted for player 1.
- frame_start coincident with DONE for player 0 at score 123 -> display shows 1/2/3 on that same edge (write-through).
